// File: rtl/pc_pkg.sv
// Shared types and helpers for the Mini-MIPS program counter unit.
// The optional return-address stack is enabled with the PC_RAS_EN macro.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

    // Word offset to byte offset, sign-extended wide enough for any sane bus width.
    function automatic logic [63:0] sext_shift(input logic [15:0] off);
        return {{46{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Only instantiated by pc_unit when PC_RAS_EN is defined.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptrInc;
    logic [PTR_W-1:0] ptrDec;
    logic [CNT_W-1:0] count;

    assign ptrInc = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    assign ptrDec = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptrInc;
            if (count != CNT_W'(DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && (count != '0)) begin
            ptr   <= ptrDec;
            count <= count - CNT_W'(1);
        end
    end

    // Storage carries no reset; emptiness is tracked purely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptrInc] <= push_data;
        end
    end

    assign valid = (count != '0);
    assign top   = valid ? mem[ptr] : '0;

endmodule

// File: rtl/pc_unit.sv
// Program counter unit: next-PC selection, fetch handshake, halt/resume, EPC and JR alignment check.
// Define PC_RAS_EN to add the return-address stack (jal, ras_top, ras_valid).
module pc_unit
    import pc_pkg::*;
#(
    parameter int                   BUS_WIDTH    = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = BUS_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [BUS_WIDTH-1:0] EXC_VECTOR   = BUS_WIDTH'(DEFAULT_EXC_VECTOR),
    parameter int                   RAS_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 fetch_ready,
    input  logic                 branch_taken,
    input  logic [15:0]          branch_offset,
    input  logic                 jump,
    input  logic [25:0]          jump_index,
    input  logic                 jump_reg,
    input  logic [BUS_WIDTH-1:0] jump_reg_target,
    input  logic                 exception,
    input  logic                 halt,
    input  logic                 resume,
    output logic [BUS_WIDTH-1:0] pc,
    output logic [BUS_WIDTH-1:0] pc_plus4,
    output logic                 fetch_valid,
    output logic [BUS_WIDTH-1:0] epc,
    output logic                 misaligned,
    output pc_state_t            state
`ifdef PC_RAS_EN
    ,
    input  logic                 jal,
    output logic [BUS_WIDTH-1:0] ras_top,
    output logic                 ras_valid
`endif
);

    if (BUS_WIDTH < 28 || RAS_DEPTH < 1) begin : g_param_check
        $error("pc_unit: BUS_WIDTH must be >= 28 and RAS_DEPTH >= 1");
    end

    pc_state_t            stateNext;
    logic [BUS_WIDTH-1:0] pcNext;
    logic [BUS_WIDTH-1:0] epcNext;
    logic                 misNext;
    logic                 advance;
    logic [BUS_WIDTH-1:0] branchTarget;
    logic [BUS_WIDTH-1:0] jumpTarget;

    assign pc_plus4     = pc + BUS_WIDTH'(4);
    assign fetch_valid  = (state == RUN);
    assign advance      = (state == RUN) && fetch_ready && !stall;
    assign branchTarget = pc_plus4 + BUS_WIDTH'($signed(sext_shift(branch_offset)));

    // J/JAL keeps the 256 MB region of the delay-slot address.
    if (BUS_WIDTH > 28) begin : g_jump_hi
        assign jumpTarget = {pc_plus4[BUS_WIDTH-1:28], jump_index, 2'b00};
    end else begin : g_jump_lo
        assign jumpTarget = {jump_index, 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            epc        <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            epc        <= epcNext;
            misaligned <= misNext;
        end
    end

    // Exception outranks everything, then halt, then the advancing redirect sources.
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        epcNext   = epc;
        misNext   = misaligned;
        if (exception) begin
            pcNext    = EXC_VECTOR;
            epcNext   = pc;
            stateNext = RUN;
        end else begin
            case (state)
                BOOT: stateNext = RUN;
                RUN: begin
                    if (halt) begin
                        stateNext = HALT;
                    end else if (advance) begin
                        if (jump_reg) begin
                            pcNext = {jump_reg_target[BUS_WIDTH-1:2], 2'b00};
                            if (jump_reg_target[1:0] != 2'b00) begin
                                misNext = 1'b1;
                            end
                        end else if (branch_taken) begin
                            pcNext = branchTarget;
                        end else if (jump) begin
                            pcNext = jumpTarget;
                        end else begin
                            pcNext = pc_plus4;
                        end
                    end
                end
                HALT: begin
                    if (resume) begin
                        stateNext = RUN;
                    end
                end
                default: stateNext = BOOT;
            endcase
        end
    end

`ifdef PC_RAS_EN
    logic rasPush;
    logic rasPop;
    logic rasAdvance;

    assign rasAdvance = advance && !exception && !halt;
    assign rasPush    = rasAdvance && !jump_reg && !branch_taken && jump && jal;
    assign rasPop     = rasAdvance && jump_reg;

    pc_ras #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rasPush),
        .pop       (rasPop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .valid     (ras_valid)
    );
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic against a behavioural model.
// Build with PC_RAS_EN defined to also exercise the return-address stack.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, fetch_ready, branch_taken, jump, jump_reg, exception, halt, resume, jal;
    logic [15:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] jump_reg_target;
    logic [31:0] pc, pc_plus4, epc;
    logic        fetch_valid, misaligned;
    logic [1:0]  state;
`ifdef PC_RAS_EN
    logic [31:0] ras_top;
    logic        ras_valid;
`endif

    int total = 0;
    int bad = 0;

    // Behavioural model: mode 0 = booting, 1 = running, 2 = halted.
    logic [31:0] mPc, mEpc;
    logic        mMis;
    int          mMode;
    logic [31:0] rasQ[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .fetch_ready     (fetch_ready),
        .branch_taken    (branch_taken),
        .branch_offset   (branch_offset),
        .jump            (jump),
        .jump_index      (jump_index),
        .jump_reg        (jump_reg),
        .jump_reg_target (jump_reg_target),
        .exception       (exception),
        .halt            (halt),
        .resume          (resume),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .epc             (epc),
        .misaligned      (misaligned),
        .state           (state)
`ifdef PC_RAS_EN
        ,
        .jal             (jal),
        .ras_top         (ras_top),
        .ras_valid       (ras_valid)
`endif
    );

    task automatic clearInputs();
        stall = 0; fetch_ready = 1; branch_taken = 0; branch_offset = '0;
        jump = 0; jump_index = '0; jump_reg = 0; jump_reg_target = '0;
        exception = 0; halt = 0; resume = 0; jal = 0;
    endtask

    task automatic resetModel();
        mPc = 32'h0; mEpc = 32'h0; mMis = 0; mMode = 0;
        rasQ.delete();
    endtask

    task automatic modelStep();
        logic [31:0] nxt;
        nxt = mPc + 32'd4;
        if (exception) begin
            mEpc = mPc;
            mPc = 32'h80;
            mMode = 1;
        end else if (mMode == 0) begin
            mMode = 1;
        end else if (mMode == 2) begin
            if (resume) mMode = 1;
        end else if (halt) begin
            mMode = 2;
        end else if (fetch_ready && !stall) begin
            if (jump_reg) begin
                if (jump_reg_target % 4 != 0) mMis = 1;
                mPc = jump_reg_target - (jump_reg_target % 4);
                if (rasQ.size() > 0) void'(rasQ.pop_back());
            end else if (branch_taken) begin
                mPc = nxt + 32'(int'($signed(branch_offset)) * 4);
            end else if (jump) begin
                mPc = (nxt & 32'hF000_0000) + 32'(jump_index) * 32'd4;
                if (jal) begin
                    rasQ.push_back(nxt);
                    if (rasQ.size() > 4) void'(rasQ.pop_front());
                end
            end else begin
                mPc = nxt;
            end
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 0;
        clearInputs();
        resetModel();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic gotoPc(input logic [31:0] target);
        clearInputs();
        jump_reg = 1; jump_reg_target = target;
        tick();
        clearInputs();
    endtask

    task automatic test_reset();
        doReset();
        tick();
        gotoPc(32'h0000_0203);
        exception = 1;
        tick();
        clearInputs();
        // Drop reset between clock edges to show it acts without a clock.
        #3;
        rst_n = 0;
        resetModel();
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 32'h0); end
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
        total++; if (epc !== 32'h0) begin bad++; $display("[TB] FAIL reset_epc: got %h want 0", epc); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("[TB] FAIL reset_misaligned: got %b want 0", misaligned); end
        @(posedge clk);
        #1;
        rst_n = 1;
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL boot_fetch_valid: got %b want 0", fetch_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (fetch_valid !== 1'b1) begin bad++; $display("[TB] FAIL run_fetch_valid: got %b want 1", fetch_valid); end
            total++; if (pc !== 32'(i * 4)) begin bad++; $display("[TB] FAIL freerun_pc: got %h want %h", pc, 32'(i * 4)); end
        end
    endtask

    task automatic test_branch_jump();
        gotoPc(32'h100);
        branch_taken = 1; branch_offset = 16'hFFFE;
        tick();
        clearInputs();
        total++; if (pc !== 32'h0FC) begin bad++; $display("[TB] FAIL branch_back: got %h want %h", pc, 32'h0FC); end
        jump = 1; jump_index = 26'h000040;
        tick();
        clearInputs();
        total++; if (pc !== 32'h100) begin bad++; $display("[TB] FAIL jump_index: got %h want %h", pc, 32'h100); end
    endtask

    task automatic test_stall();
        gotoPc(32'h20);
        stall = 1; branch_taken = 1; branch_offset = 16'h0003;
        tick();
        total++; if (pc !== 32'h20) begin bad++; $display("[TB] FAIL stall_hold: got %h want %h", pc, 32'h20); end
        stall = 0;
        tick();
        clearInputs();
        total++; if (pc !== 32'h30) begin bad++; $display("[TB] FAIL stall_release_branch: got %h want %h", pc, 32'h30); end
        fetch_ready = 0;
        tick();
        clearInputs();
        total++; if (pc !== 32'h30) begin bad++; $display("[TB] FAIL not_ready_hold: got %h want %h", pc, 32'h30); end
    endtask

    task automatic test_misaligned();
        doReset();
        tick();
        gotoPc(32'h0000_0203);
        total++; if (pc !== 32'h200) begin bad++; $display("[TB] FAIL jr_target: got %h want %h", pc, 32'h200); end
        total++; if (misaligned !== 1'b1) begin bad++; $display("[TB] FAIL misaligned_set: got %b want 1", misaligned); end
        gotoPc(32'h0000_0300);
        tick();
        total++; if (misaligned !== 1'b1) begin bad++; $display("[TB] FAIL misaligned_sticky: got %b want 1", misaligned); end
    endtask

    task automatic test_exception_halt();
        gotoPc(32'h44);
        stall = 1; exception = 1;
        tick();
        clearInputs();
        total++; if (pc !== 32'h80) begin bad++; $display("[TB] FAIL exc_pc: got %h want %h", pc, 32'h80); end
        total++; if (epc !== 32'h44) begin bad++; $display("[TB] FAIL exc_epc: got %h want %h", epc, 32'h44); end
        halt = 1;
        tick();
        clearInputs();
        total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL halt_state: got %0d want 2", state); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc !== 32'h80 || fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_frozen: pc %h fv %b want 80 0", pc, fetch_valid); end
        end
        resume = 1;
        tick();
        clearInputs();
        total++; if (state !== 2'd1 || pc !== 32'h80) begin bad++; $display("[TB] FAIL resume: state %0d pc %h want 1 80", state, pc); end
        tick();
        total++; if (pc !== 32'h84) begin bad++; $display("[TB] FAIL resume_continue: got %h want %h", pc, 32'h84); end
    endtask

    task automatic test_wrap();
        gotoPc(32'hFFFF_FFFC);
        total++; if (pc_plus4 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_plus4: got %h want 0", pc_plus4); end
        tick();
        total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc: got %h want 0", pc); end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras();
        logic [31:0] want;
        doReset();
        tick();
        for (int i = 0; i < 5; i++) begin
            jump = 1; jal = 1; jump_index = 26'(32'h40 * (i + 1));
            tick();
        end
        clearInputs();
        for (int k = 0; k < 4; k++) begin
            want = 32'h404 - 32'h100 * k;
            total++; if (ras_top !== want || ras_valid !== 1'b1) begin bad++; $display("[TB] FAIL ras_pop_order: top %h valid %b want %h 1", ras_top, ras_valid, want); end
            jump_reg = 1; jump_reg_target = 32'h1000;
            tick();
            clearInputs();
        end
        total++; if (ras_valid !== 1'b0) begin bad++; $display("[TB] FAIL ras_empty: got %b want 0", ras_valid); end
    endtask
`endif

    task automatic test_random();
        doReset();
        for (int n = 0; n < 600; n++) begin
            clearInputs();
            stall = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            branch_offset = 16'($urandom);
            jump = ($urandom_range(0, 3) == 0);
            jal = $urandom_range(0, 1) == 1;
            jump_index = 26'($urandom);
            jump_reg = ($urandom_range(0, 5) == 0);
            jump_reg_target = $urandom;
            exception = ($urandom_range(0, 31) == 0);
            halt = ($urandom_range(0, 23) == 0);
            resume = ($urandom_range(0, 3) == 0);
            tick();
            total++; if (pc !== mPc) begin bad++; $display("[TB] FAIL rand_pc: got %h want %h", pc, mPc); end
            total++; if (pc_plus4 !== mPc + 32'd4) begin bad++; $display("[TB] FAIL rand_plus4: got %h want %h", pc_plus4, mPc + 32'd4); end
            total++; if (epc !== mEpc) begin bad++; $display("[TB] FAIL rand_epc: got %h want %h", epc, mEpc); end
            total++; if (misaligned !== mMis) begin bad++; $display("[TB] FAIL rand_misaligned: got %b want %b", misaligned, mMis); end
            total++; if (state !== 2'(mMode) || fetch_valid !== (mMode == 1)) begin bad++; $display("[TB] FAIL rand_state: state %0d fv %b want %0d", state, fetch_valid, mMode); end
`ifdef PC_RAS_EN
            total++; if (ras_valid !== (rasQ.size() > 0) || (rasQ.size() > 0 && ras_top !== rasQ[$])) begin bad++; $display("[TB] FAIL rand_ras: top %h valid %b want depth %0d", ras_top, ras_valid, rasQ.size()); end
`endif
        end
    endtask

    initial begin
        clearInputs();
        resetModel();
        test_reset();
        test_branch_jump();
        test_stall();
        test_misaligned();
        test_exception_halt();
        test_wrap();
`ifdef PC_RAS_EN
        test_ras();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
